dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the MEM stage of the MIPS pipeline: serves the word load/store requests the pipeline issues from EX/MEM, with a fixed multi-cycle access latency. While an access is in flight it raises `stall` so the hazard logic freezes PC, IF/ID, ID/EX and EX/MEM. When the access finishes it returns read data, or a commit acknowledgement for a store, with a one-cycle `ready` pulse.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, 2..65536.
- `LATENCY`, default 2: cycles from request acceptance to `ready`; legal range 1..15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `memread`, input, 1: load request from EX/MEM.
- `memwrite`, input, 1: store request from EX/MEM.
- `address`, input, 32: byte address; word index is `address[31:2]`.
- `writedata`, input, 32: store data.
- `readdata`, output, 32: load result; registered; valid while `ready`=1.
- `ready`, output, 1: one-cycle completion pulse.
- `err`, output, 1: request rejected; meaningful only while `ready`=1.
- `stall`, output, 1: combinational; pipeline must hold the request stable while it is 1.

## Operation
- A request is present when `memread|memwrite` = 1.
- FSM states:
  - IDLE:
    - No request: stay in IDLE.
    - Request present: accept it. Latch the operation, the word index and `writedata`, and load the counter with `LATENCY-1`.
    - If `LATENCY`=1, go to RESP. Otherwise go to BUSY.
  - BUSY:
    - Decrement the counter each cycle.
    - When the counter is 1 at the clock edge, go to RESP.
  - RESP:
    - `ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- `stall` = (IDLE and request present) or BUSY. It is 0 in RESP so the pipeline advances on that edge.
- The access happens on the edge that enters RESP, using the latched request:
  - Store: `mem[idx] <= wdata`; `readdata` unchanged.
  - Load: `readdata <= mem[idx]`.
- Errors (detected at acceptance and latched):
  - `memread` and `memwrite` both 1.
  - `address[1:0]` ≠ 0.
  - `address[31:2]` ≥ `DEPTH_WORDS`.
- On an error: no array write; `readdata <= 0`; `err`=1 together with `ready`.
- The request is sampled only in IDLE. Input changes during BUSY/RESP are ignored. A request still present in the IDLE cycle after RESP is a new request.
- Back-to-back store then load to the same word: the load returns the stored value.
- The memory array is not cleared by `reset`; contents are preserved.

## Timing
- Reset values: state=IDLE, counter=0, `readdata`=0, `ready`=0, `err`=0. `stall` then follows the inputs combinationally (1 if a request is present).
- Latency: a request seen in IDLE in cycle 0 gets `ready` in cycle `LATENCY`; `stall`=1 for cycles 0..`LATENCY`-1.
- Peak throughput is one access per `LATENCY`+1 cycles (including the IDLE acceptance cycle).
- `readdata` holds its value from the last completed load or error until the next load or error completes.
- `reset` asserted mid-access: return to IDLE immediately; an in-flight store is dropped, not committed; no `ready` pulse.
- Counter width is 4 bits; counting does not wrap for any legal `LATENCY`.

## Test plan
- Reset then idle: assert `reset`, deassert, no requests → `ready`=0, `err`=0, `stall`=0, `readdata`=0 for 10 cycles.
- Store/load round trip, `LATENCY`=2:
  - Store 0xDEADBEEF to 0x0000_0010 → `stall`=1 in cycles 0-1; `ready`=1 and `err`=0 in cycle 2.
  - Then load 0x10 → `readdata`=0xDEADBEEF with `ready`=1 in cycle 2 of that access.
- Latency sweep: `LATENCY`=1 → `ready` in cycle 1 with `stall` high only in cycle 0; `LATENCY`=15 → `ready` in cycle 15.
- Errors, one request each:
  - Address 0x0000_0012 (misaligned) → `err`=1, `readdata`=0.
  - Address `DEPTH_WORDS`*4 (out of range) → `err`=1.
  - `memread`=`memwrite`=1 → `err`=1 and word 0 of the array unchanged.
- Reset mid-store: store 0x12345678 to 0x20, assert `reset` in BUSY → no `ready`; a later load of 0x20 returns the prior contents.
- Input ignored while busy: change `address` from 0x20 to 0x24 during BUSY → the response is for 0x20.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage word load/store responder with fixed access latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_write;
  logic           r_err;
  logic [AW-1:0]  r_idx;
  logic [31:0]    r_wdata;
  logic [31:0]    r_readdata;
  logic           r_ready;
  logic           r_err_out;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_req;
  logic           w_req_err;
  logic           w_idle;
  logic           w_go_resp;
  logic           w_acc_write;
  logic           w_acc_err;
  logic [AW-1:0]  w_acc_idx;
  logic [31:0]    w_acc_wdata;
  logic           w_mem_we;

  assign w_req     = memread | memwrite;
  assign w_req_err = (memread & memwrite) | (|address[1:0]) |
                     ({2'b00, address[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idle    = (r_state == S_IDLE);

  // With LATENCY=1 the access edge is the acceptance edge, so the live
  // request is used instead of the not-yet-latched copy.
  assign w_go_resp   = (w_idle && w_req && (LATENCY == 1)) ||
                       ((r_state == S_BUSY) && (r_cnt == 4'd1));
  assign w_acc_write = w_idle ? memwrite            : r_write;
  assign w_acc_err   = w_idle ? w_req_err           : r_err;
  assign w_acc_idx   = w_idle ? address[AW+1:2]     : r_idx;
  assign w_acc_wdata = w_idle ? writedata           : r_wdata;
  assign w_mem_we    = w_go_resp && w_acc_write && !w_acc_err && !reset;

  assign stall    = (w_idle && w_req) || (r_state == S_BUSY);
  assign readdata = r_readdata;
  assign ready    = r_ready;
  assign err      = r_err_out;

  // Array contents survive reset, so it lives outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_readdata <= 32'd0;
      r_ready    <= 1'b0;
      r_err_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_write <= memwrite;
            r_err   <= w_req_err;
            r_idx   <= address[AW+1:2];
            r_wdata <= writedata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_go_resp) begin
        r_ready   <= 1'b1;
        r_err_out <= w_acc_err;
        if (w_acc_err) begin
          r_readdata <= 32'd0;
        end else if (!w_acc_write) begin
          r_readdata <= r_mem[w_acc_idx];
        end
      end else begin
        r_ready   <= 1'b0;
        r_err_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        err;
  logic        stall;

  logic        s_memread;
  logic        s_memwrite;
  logic [31:0] s_address;
  logic [31:0] s_writedata;
  logic [31:0] readdata_1;
  logic        ready_1;
  logic        err_1;
  logic        stall_1;
  logic [31:0] readdata_15;
  logic        ready_15;
  logic        err_15;
  logic        stall_15;

  int n_checks;
  int n_pass;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .writedata(writedata), .readdata(readdata),
    .ready(ready), .err(err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .memread(s_memread), .memwrite(s_memwrite),
    .address(s_address), .writedata(s_writedata), .readdata(readdata_1),
    .ready(ready_1), .err(err_1), .stall(stall_1)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_dut_lat15 (
    .clk(clk), .reset(reset), .memread(s_memread), .memwrite(s_memwrite),
    .address(s_address), .writedata(s_writedata), .readdata(readdata_15),
    .ready(ready_15), .err(err_15), .stall(stall_15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access on the LATENCY=2 instance: request held until ready, stall
  // recorded per cycle (bit k = cycle k), optional address swap while busy.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic swap, input logic [31:0] addr2,
                        output logic [31:0] rdata, output logic rerr,
                        output int lat, output logic [15:0] sv);
    int k;
    @(posedge clk); #1;
    memread   = rd;
    memwrite  = wr;
    address   = addr;
    writedata = wd;
    sv    = 16'd0;
    lat   = -1;
    rdata = 32'd0;
    rerr  = 1'b0;
    for (k = 0; k < 32; k++) begin
      @(negedge clk);
      sv[k[3:0]] = stall;
      if (swap && k == 1) address = addr2;
      if (ready) begin
        lat   = k;
        rdata = readdata;
        rerr  = err;
        break;
      end
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    if (lat < 0) check("access_timeout", 32'(k), 32'd2);
  endtask

  logic [31:0] rd_v;
  logic        er_v;
  int          lat_v;
  logic [15:0] sv_v;
  logic        any_ready, any_err, any_stall, any_rd;
  int          r1, r15;
  logic        st1_c0, st1_c1, st15_c0, st15_c14, e1, e15;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    memread = 1'b0; memwrite = 1'b0; address = 32'd0; writedata = 32'd0;
    s_memread = 1'b0; s_memwrite = 1'b0; s_address = 32'd0; s_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    any_ready = 0; any_err = 0; any_stall = 0; any_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_ready |= ready;
      any_err   |= err;
      any_stall |= stall;
      any_rd    |= (|readdata);
    end
    check("reset_ready", 32'(any_ready), 32'd0);
    check("reset_err", 32'(any_err), 32'd0);
    check("reset_stall", 32'(any_stall), 32'd0);
    check("reset_readdata", 32'(any_rd), 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("store10_lat", 32'(lat_v), 32'd2);
    check("store10_stall", 32'(sv_v), 32'h3);
    check("store10_err", 32'(er_v), 32'd0);
    check("store10_readdata_hold", rd_v, 32'd0);

    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("load10_data", rd_v, 32'hDEADBEEF);
    check("load10_lat", 32'(lat_v), 32'd2);
    check("load10_err", 32'(er_v), 32'd0);

    access(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    access(1'b0, 1'b1, 32'h24, 32'h11111111, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("store24_err", 32'(er_v), 32'd0);

    access(1'b1, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("misalign_err", 32'(er_v), 32'd1);
    check("misalign_readdata", rd_v, 32'd0);
    check("misalign_lat", 32'(lat_v), 32'd2);

    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("reload10_data", rd_v, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("range_err", 32'(er_v), 32'd1);
    check("range_readdata", rd_v, 32'd0);

    access(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("dualop_err", 32'(er_v), 32'd1);
    access(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("dualop_word0", rd_v, 32'hCAFEF00D);
    check("word0_err", 32'(er_v), 32'd0);

    // Back-to-back store then load of the same word.
    access(1'b0, 1'b1, 32'h30, 32'hA5A55A5A, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("b2b_data", rd_v, 32'hA5A55A5A);
    check("b2b_lat", 32'(lat_v), 32'd2);

    // Reset while a store is in BUSY: dropped, no ready.
    @(posedge clk); #1;
    memwrite = 1'b1; address = 32'h20; writedata = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b1;
    memwrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    any_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      any_ready |= ready;
    end
    check("rstmid_ready", 32'(any_ready), 32'd0);
    check("rstmid_readdata", readdata, 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, rd_v, er_v, lat_v, sv_v);
    check("rstmid_prior", rd_v, 32'h0BADF00D);

    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h24, rd_v, er_v, lat_v, sv_v);
    check("busy_ignore", rd_v, 32'h0BADF00D);

    // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
    @(posedge clk); #1;
    s_memwrite = 1'b1; s_address = 32'h40; s_writedata = 32'h55AA55AA;
    r1 = -1; r15 = -1;
    st1_c0 = 0; st1_c1 = 1; st15_c0 = 0; st15_c14 = 0; e1 = 1; e15 = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin st1_c0 = stall_1; st15_c0 = stall_15; end
      if (k == 1) begin st1_c1 = stall_1; s_memwrite = 1'b0; end
      if (k == 14) st15_c14 = stall_15;
      if (ready_1 && r1 < 0) begin r1 = k; e1 = err_1; end
      if (ready_15 && r15 < 0) begin r15 = k; e15 = err_15; end
    end
    check("lat1_ready_cycle", 32'(r1), 32'd1);
    check("lat1_stall_c0", 32'(st1_c0), 32'd1);
    check("lat1_stall_c1", 32'(st1_c1), 32'd0);
    check("lat1_err", 32'(e1), 32'd0);
    check("lat15_ready_cycle", 32'(r15), 32'd15);
    check("lat15_stall_c0", 32'(st15_c0), 32'd1);
    check("lat15_stall_c14", 32'(st15_c14), 32'd1);
    check("lat15_err", 32'(e15), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
